btn_event_gen: RTL and testbench

- Sits directly downstream of the button debouncer; consumes its 5 debounced, synchronized button levels.
- Generates single-cycle press, release, long-press and auto-repeat pulses per button.
- Latches the most recent press/repeat as a key code with a valid/ack handshake, for the CPU I/O register map or for UI FSMs.
- All logic runs on one clock domain; btn_db is already synchronous, so no extra synchronizers are needed.

---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_evt_fsm.sv | 131 +++++++++++++
 rtl/btn_event_gen.sv | 106 ++++++++++
 tb/tb_btn_event_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button event generator.
//   btn_state_e      per-button FSM state (2-bit encoding)
//   KEY_W            width of the latched key code
//   *_DEF            default timing and counter-width constants
package btn_pkg;

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    IDLE     = 2'd1,
    PRESSED  = 2'd2,
    HELD     = 2'd3
  } btn_state_e;

  localparam int KEY_W           = 3;
  localparam int LONG_TIME_DEF   = 50_000_000;
  localparam int REPEAT_TIME_DEF = 10_000_000;
  localparam int CNT_WIDTH_DEF   = 26;

endpackage

// File: rtl/btn_evt_fsm.sv
// Per-button event FSM: turns one debounced level into registered
// press / release / long / repeat pulses.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   btn             debounced level of this button (1 = pressed)
//   press_o         1-cycle pulse on press
//   release_o       1-cycle pulse on release
//   long_o          1-cycle pulse when the hold reaches LONG_TIME
//   repeat_o        1-cycle pulse every REPEAT_TIME after the long pulse
//   press_nxt_o     value press_o takes on the next edge
//   repeat_nxt_o    value repeat_o takes on the next edge
module btn_evt_fsm
  import btn_pkg::*;
#(
  parameter int LONG_TIME   = LONG_TIME_DEF,
  parameter int REPEAT_TIME = REPEAT_TIME_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o,
  output logic press_nxt_o,
  output logic repeat_nxt_o
);

  localparam logic [CNT_WIDTH-1:0] LONG_CNT   = CNT_WIDTH'(LONG_TIME);
  localparam logic [CNT_WIDTH-1:0] REPEAT_CNT = CNT_WIDTH'(REPEAT_TIME);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  btn_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 long_q, long_d;
  logic                 repeat_q, repeat_d;

  // State, counter and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_REL;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  // Next state and hold counter. The counter restarts at 1 on every
  // press, long and repeat so each interval is measured from its own edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_REL: begin
        if (!btn) state_d = IDLE;
      end
      IDLE: begin
        if (btn) begin
          state_d = PRESSED;
          cnt_d   = CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LONG_CNT) begin
          state_d = HELD;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REPEAT_CNT) begin
          cnt_d = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = WAIT_REL;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulse decode. Release is tested first in both hold states, so it
  // wins over long/repeat when both would fire on the same edge.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    unique case (state_q)
      IDLE:    press_d = btn;
      PRESSED: begin
        release_d = !btn;
        long_d    = btn && (cnt_q == LONG_CNT);
      end
      HELD: begin
        release_d = !btn;
        repeat_d  = btn && (cnt_q == REPEAT_CNT);
      end
      default: ;
    endcase
  end

  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_o       = long_q;
  assign repeat_o     = repeat_q;
  assign press_nxt_o  = press_d;
  assign repeat_nxt_o = repeat_d;

endmodule

// File: rtl/btn_event_gen.sv
// Button event generator: one event FSM per debounced button plus a
// key latch that records the lowest-index press/repeat for a consumer.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   btn_db          debounced button levels (1 = pressed)
//   btn_press       1-cycle press pulses
//   btn_release     1-cycle release pulses
//   btn_long        1-cycle long-press pulses
//   btn_repeat      1-cycle auto-repeat pulses
//   key_valid       latched key event pending
//   key_code        index of the latched button
//   key_ovf         an event arrived while a key was pending and unacked
//   key_ack         consumer acknowledges the latched key
module btn_event_gen
  import btn_pkg::*;
#(
  parameter int N_BTN       = 5,
  parameter int LONG_TIME   = LONG_TIME_DEF,
  parameter int REPEAT_TIME = REPEAT_TIME_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_code,
  output logic             key_ovf,
  input  logic             key_ack
);

  logic [N_BTN-1:0] press_nxt;
  logic [N_BTN-1:0] repeat_nxt;
  logic [N_BTN-1:0] ev;

  logic             key_valid_q, key_valid_d;
  logic [KEY_W-1:0] key_code_q, key_code_d;
  logic             key_ovf_q, key_ovf_d;

  function automatic logic [KEY_W-1:0] lowest_idx(input logic [N_BTN-1:0] v);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (v[i]) idx = KEY_W'(i);
    end
    return idx;
  endfunction

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_evt_fsm #(
      .LONG_TIME  (LONG_TIME),
      .REPEAT_TIME(REPEAT_TIME),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_fsm (
      .clk         (clk),
      .rst         (rst),
      .btn         (btn_db[g]),
      .press_o     (btn_press[g]),
      .release_o   (btn_release[g]),
      .long_o      (btn_long[g]),
      .repeat_o    (btn_repeat[g]),
      .press_nxt_o (press_nxt[g]),
      .repeat_nxt_o(repeat_nxt[g])
    );
  end

  // The latch reacts to the FSMs' next-state pulses so the key appears
  // on the same edge as the corresponding btn_press/btn_repeat pulse.
  assign ev = press_nxt | repeat_nxt;

  always_comb begin
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    key_ovf_d   = key_ovf_q;
    if (ev != '0) begin
      key_valid_d = 1'b1;
      key_code_d  = lowest_idx(ev);
      if (key_ack)          key_ovf_d = 1'b0;
      else if (key_valid_q) key_ovf_d = 1'b1;
    end else if (key_ack) begin
      key_valid_d = 1'b0;
      key_ovf_d   = 1'b0;
    end
  end

  // Key latch registers
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_ovf_q   <= 1'b0;
    end else begin
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ovf_q   <= key_ovf_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_ovf   = key_ovf_q;

endmodule

// File: tb/tb_btn_event_gen.sv
module tb_btn_event_gen;

  localparam int NB   = 5;
  localparam int LT   = 8;
  localparam int RT   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_db = '0;
  logic          key_ack = 1'b0;
  logic [NB-1:0] btn_press, btn_release, btn_long, btn_repeat;
  logic          key_valid, key_ovf;
  logic [2:0]    key_code;

  int n_chk  = 0;
  int n_fail = 0;

  btn_event_gen #(
    .N_BTN      (NB),
    .LONG_TIME  (LT),
    .REPEAT_TIME(RT),
    .CNT_WIDTH  (26)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_db     (btn_db),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .btn_repeat (btn_repeat),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ovf    (key_ovf),
    .key_ack    (key_ack)
  );

  always #5 clk = ~clk;

  // Reference model: per button, whether it has been seen released since
  // reset, whether it is currently held, and how many edges since press.
  bit      m_armed [NB];
  bit      m_held  [NB];
  int      m_age   [NB];
  bit      m_valid;
  int      m_code;
  bit      m_ovf;
  logic [31:0] m_vec;

  typedef struct {
    logic          r;
    logic [NB-1:0] b;
    logic          a;
    logic [NB-1:0] p, rl, lg, rp;
    logic          v;
    logic [2:0]    c;
    logic          o;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [31:0] pack(input logic [NB-1:0] p, input logic [NB-1:0] rl,
                                       input logic [NB-1:0] lg, input logic [NB-1:0] rp,
                                       input logic v, input logic [2:0] c, input logic o);
    return {7'd0, p, rl, lg, rp, v, c, o};
  endfunction

  function automatic logic [31:0] dut_vec();
    return pack(btn_press, btn_release, btn_long, btn_repeat, key_valid, key_code, key_ovf);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [NB-1:0] b, input logic a);
    logic [NB-1:0] p, rl, lg, rp, ev;
    p = '0; rl = '0; lg = '0; rp = '0;
    if (r) begin
      for (int i = 0; i < NB; i++) begin
        m_armed[i] = 0; m_held[i] = 0; m_age[i] = 0;
      end
      m_valid = 0; m_code = 0; m_ovf = 0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (!m_armed[i]) begin
          if (!b[i]) m_armed[i] = 1;
        end else if (!m_held[i]) begin
          if (b[i]) begin
            p[i] = 1; m_held[i] = 1; m_age[i] = 0;
          end
        end else begin
          m_age[i]++;
          if (!b[i]) begin
            rl[i] = 1; m_held[i] = 0;
          end else if (m_age[i] == LT) begin
            lg[i] = 1;
          end else if (m_age[i] > LT && ((m_age[i] - LT) % RT) == 0) begin
            rp[i] = 1;
          end
        end
      end
      ev = p | rp;
      if (ev != 0) begin
        if (a) m_ovf = 0;
        else if (m_valid) m_ovf = 1;
        m_valid = 1;
        for (int i = NB - 1; i >= 0; i--) if (ev[i]) m_code = i;
      end else if (a) begin
        m_valid = 0; m_ovf = 0;
      end
    end
    m_vec = pack(p, rl, lg, rp, m_valid, 3'(m_code), m_ovf);
  endtask

  // Drive inputs, advance one edge, compare the whole output set to the model.
  task automatic step(input logic r, input logic [NB-1:0] b, input logic a);
    rst = r; btn_db = b; key_ack = a;
    model_edge(r, b, a);
    @(posedge clk);
    #1;
    chk("model", dut_vec(), m_vec);
  endtask

  initial begin
    int cnt;
    logic [NB-1:0] rb;

    // Reset state
    step(1'b1, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    chk("reset", dut_vec(), 32'd0);

    // Short press, simultaneous press with ovf, ack, ack collision
    tbl[0]  = '{0, 5'b00000, 0, 5'b00000, 5'b00000, 5'b0, 5'b0, 0, 3'd0, 0};
    tbl[1]  = '{0, 5'b00100, 0, 5'b00100, 5'b00000, 5'b0, 5'b0, 1, 3'd2, 0};
    tbl[2]  = '{0, 5'b00100, 0, 5'b00000, 5'b00000, 5'b0, 5'b0, 1, 3'd2, 0};
    tbl[3]  = '{0, 5'b00100, 0, 5'b00000, 5'b00000, 5'b0, 5'b0, 1, 3'd2, 0};
    tbl[4]  = '{0, 5'b00000, 0, 5'b00000, 5'b00100, 5'b0, 5'b0, 1, 3'd2, 0};
    tbl[5]  = '{0, 5'b00000, 0, 5'b00000, 5'b00000, 5'b0, 5'b0, 1, 3'd2, 0};
    tbl[6]  = '{0, 5'b11000, 0, 5'b11000, 5'b00000, 5'b0, 5'b0, 1, 3'd3, 1};
    tbl[7]  = '{0, 5'b11000, 1, 5'b00000, 5'b00000, 5'b0, 5'b0, 0, 3'd3, 0};
    tbl[8]  = '{0, 5'b00000, 0, 5'b00000, 5'b11000, 5'b0, 5'b0, 0, 3'd3, 0};
    tbl[9]  = '{0, 5'b00000, 1, 5'b00000, 5'b00000, 5'b0, 5'b0, 0, 3'd3, 0};
    tbl[10] = '{0, 5'b00001, 0, 5'b00001, 5'b00000, 5'b0, 5'b0, 1, 3'd0, 0};
    tbl[11] = '{0, 5'b00000, 0, 5'b00000, 5'b00001, 5'b0, 5'b0, 1, 3'd0, 0};
    tbl[12] = '{0, 5'b00010, 0, 5'b00010, 5'b00000, 5'b0, 5'b0, 1, 3'd1, 1};
    tbl[13] = '{0, 5'b00011, 1, 5'b00001, 5'b00000, 5'b0, 5'b0, 1, 3'd0, 0};
    tbl[14] = '{0, 5'b00000, 0, 5'b00000, 5'b00011, 5'b0, 5'b0, 1, 3'd0, 0};
    tbl[15] = '{0, 5'b00000, 1, 5'b00000, 5'b00000, 5'b0, 5'b0, 0, 3'd0, 0};
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].r, tbl[i].b, tbl[i].a);
      chk($sformatf("table[%0d]", i), dut_vec(),
          pack(tbl[i].p, tbl[i].rl, tbl[i].lg, tbl[i].rp, tbl[i].v, tbl[i].c, tbl[i].o));
    end

    // Held through reset: no events until released, then one press
    step(0, 5'b00001, 0);
    step(1, 5'b00001, 0);
    step(1, 5'b00001, 0);
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      step(0, 5'b00001, 0);
      if ((btn_press | btn_release | btn_long | btn_repeat) != 0) cnt++;
    end
    chk("held_reset_quiet", cnt, 0);
    step(0, 5'b00000, 0);
    chk("held_reset_norel", {27'd0, btn_release}, 32'd0);
    step(0, 5'b00001, 0);
    chk("held_reset_press", {27'd0, btn_press}, 32'd1);
    cnt = 0;
    for (int j = 0; j < 4; j++) begin
      step(0, 5'b00001, 0);
      cnt += $countones(btn_press);
    end
    chk("held_reset_once", cnt, 0);
    step(0, 5'b00000, 1);
    step(0, 5'b00000, 1);

    // Long hold with repeats on button 1 (press edge is k)
    step(0, 5'b00010, 0);
    chk("long_press", {27'd0, btn_press}, 32'd2);
    for (int j = 1; j <= 20; j++) begin
      step(0, 5'b00010, 0);
      if (j == LT) chk("long_pulse", {27'd0, btn_long}, 32'd2);
      else         chk("long_quiet", {27'd0, btn_long}, 32'd0);
      if (j == 12 || j == 16 || j == 20) begin
        chk("repeat_pulse", {27'd0, btn_repeat}, 32'd2);
        chk("repeat_code", {29'd0, key_code}, 32'd1);
      end
      if (j == 12) chk("repeat_ovf", {31'd0, key_ovf}, 32'd1);
    end
    step(0, 5'b00000, 1);
    chk("long_release", {27'd0, btn_release}, 32'd2);

    // Release sampled exactly at the long threshold
    step(0, 5'b00010, 0);
    for (int j = 1; j < LT; j++) step(0, 5'b00010, 0);
    step(0, 5'b00000, 0);
    chk("thr_release", {27'd0, btn_release}, 32'd2);
    chk("thr_nolong", {27'd0, btn_long}, 32'd0);
    step(0, 5'b00000, 1);

    // Randomized traffic against the model
    rb = '0;
    for (int j = 0; j < 4000; j++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 15) == 0) rb[i] = ~rb[i];
      step(($urandom_range(0, 299) == 0), rb, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
